// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the IF requester, MEM requester, SRAM controller
// and status signals around sram_arbiter.
//   slave  : arbiter side (requests/SRAM responses in, grants/commands out)
//   master : environment side (requesters + SRAM controller)
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch (read-only)
  logic              if_rd_en;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  // data-side cache controller
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  // SRAM controller
  logic              sram_read_en;
  logic              sram_write_en;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_write_data;
  logic [DATA_W-1:0] sram_read_data;
  logic              sram_ready;
  // status
  logic              busy;
  logic              owner;
  logic              timeout_err;

  modport slave (
    input  if_rd_en, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           sram_read_data, sram_ready,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           sram_read_en, sram_write_en, sram_address, sram_write_data,
           busy, owner, timeout_err
  );

  modport master (
    output if_rd_en, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
           sram_read_data, sram_ready,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           sram_read_en, sram_write_en, sram_address, sram_write_data,
           busy, owner, timeout_err
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one SRAM controller between
// instruction fetch (IF, read-only) and the data-side cache controller (MEM).
// The winner's command is latched for the whole transaction; completion is a
// one-cycle ready pulse to the owner only. A watchdog aborts a transaction
// that sees no sram_ready within TIMEOUT busy cycles (sticky timeout_err).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : sram_arbiter_if.slave (requesters, SRAM controller, status)
module sram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255   // 1..255
) (
  input logic         clk,
  input logic         rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic              owner_q;      // doubles as last_grant
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic              busy_q;
  logic              terr_q;
  logic [7:0]        cnt;

  logic if_req, mem_req, grant_mem, grant_wr;

  assign if_req  = bus.if_rd_en;
  assign mem_req = bus.mem_rd_en | bus.mem_wr_en;
  // On contention the side that did not win last time gets the grant.
  assign grant_mem = mem_req & (~if_req | ~owner_q);
  // rd+wr together counts as a write
  assign grant_wr  = grant_mem & bus.mem_wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
      cnt         <= '0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | mem_req) begin
            owner_q <= grant_mem;
            addr_q  <= grant_mem ? bus.mem_addr : bus.if_addr;
            wdata_q <= bus.mem_wdata;
            rd_en_q <= ~grant_wr;
            wr_en_q <= grant_wr;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // sram_ready wins over a watchdog expiry in the same cycle
          if (bus.sram_ready) begin
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            if_ready_q  <= ~owner_q;
            mem_ready_q <= owner_q;
            if (!wr_en_q) begin
              if (owner_q) mem_rdata_q <= bus.sram_read_data;
              else         if_rdata_q  <= bus.sram_read_data;
            end
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            if_ready_q  <= ~owner_q;
            mem_ready_q <= owner_q;
            terr_q      <= 1'b1;
            if (owner_q) mem_rdata_q <= '0;
            else         if_rdata_q  <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // One dead cycle so a requester's stale level is never re-granted.
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata        = if_rdata_q;
  assign bus.if_ready        = if_ready_q;
  assign bus.mem_rdata       = mem_rdata_q;
  assign bus.mem_ready       = mem_ready_q;
  assign bus.sram_read_en    = rd_en_q;
  assign bus.sram_write_en   = wr_en_q;
  assign bus.sram_address    = addr_q;
  assign bus.sram_write_data = wdata_q;
  assign bus.busy            = busy_q;
  assign bus.owner           = owner_q;
  assign bus.timeout_err     = terr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed + randomized bench for sram_arbiter (TIMEOUT=4).
// A transaction-level model predicts winner, latched command, busy length,
// ready pulse, returned data and the sticky watchdog flag.
module tb_sram_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  // reference model state
  bit          last;        // last grant: 0=IF, 1=MEM
  bit          terr;
  logic [31:0] exp_rd [2];
  bit          prev_done;   // task returned at the negedge inside DONE

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last = 1'b0; terr = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0; prev_done = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  bus.busy, 1'b0);
    chk({tag, "_rdy"},   {bus.if_ready, bus.mem_ready}, 2'b00);
    chk({tag, "_en"},    {bus.sram_read_en, bus.sram_write_en}, 2'b00);
    chk({tag, "_owner"}, bus.owner, last);
    chk({tag, "_terr"},  bus.timeout_err, terr);
  endtask

  // Drive one request pattern and follow the transaction through DONE.
  // delay = BUSY cycles without sram_ready before it arrives.
  task automatic txn(input bit ird, input bit mrd, input bit mwr,
                     input logic [31:0] ia, input logic [31:0] ma,
                     input logic [31:0] wd, input logic [31:0] rd, input int delay);
    bit eo, ewr, timed;
    logic [31:0] eaddr;
    int nb;
    bus.if_rd_en = ird; bus.mem_rd_en = mrd; bus.mem_wr_en = mwr;
    bus.if_addr = ia; bus.mem_addr = ma; bus.mem_wdata = wd;
    if (prev_done) begin
      @(posedge clk); #1;
      check_idle("after_done");
    end
    if (ird && (mrd || mwr)) eo = !last;
    else                     eo = mrd | mwr;
    ewr   = eo && mwr;
    eaddr = eo ? ma : ia;
    last  = eo;
    timed = (delay >= TO);
    nb    = timed ? TO : delay + 1;
    for (int k = 1; k <= nb; k++) begin
      @(posedge clk); #1;
      chk("busy",     bus.busy, 1'b1);
      chk("owner",    bus.owner, eo);
      chk("rd_en",    bus.sram_read_en, !ewr);
      chk("wr_en",    bus.sram_write_en, ewr);
      chk("address",  bus.sram_address, eaddr);
      if (ewr) chk("wdata", bus.sram_write_data, wd);
      chk("no_ready", {bus.if_ready, bus.mem_ready}, 2'b00);
      @(negedge clk);
      if (k == 1) begin
        // requester inputs must be ignored while busy
        bus.if_addr = ia ^ 32'hC0; bus.mem_addr = ma ^ 32'hC0; bus.mem_wdata = ~wd;
      end
      bus.sram_ready     = !timed && (k == nb);
      bus.sram_read_data = (k == nb) ? rd : $urandom;
    end
    @(posedge clk); #1;
    if (timed)     begin terr = 1'b1; exp_rd[eo] = '0; end
    else if (!ewr) exp_rd[eo] = rd;
    chk("done_busy",   bus.busy, 1'b1);
    chk("if_ready",    bus.if_ready, !eo);
    chk("mem_ready",   bus.mem_ready, eo);
    chk("if_rdata",    bus.if_rdata, exp_rd[0]);
    chk("mem_rdata",   bus.mem_rdata, exp_rd[1]);
    chk("done_en",     {bus.sram_read_en, bus.sram_write_en}, 2'b00);
    chk("timeout_err", bus.timeout_err, terr);
    @(negedge clk);
    // stray completion pulse during DONE must be ignored
    bus.sram_ready     = 1'($urandom_range(0, 1));
    bus.sram_read_data = $urandom;
    prev_done = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.if_rd_en = 1'b0; bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
    if (prev_done) begin
      @(posedge clk); #1;
      check_idle("idle_exit");
    end
    repeat (n) begin
      @(negedge clk);
      bus.sram_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_idle("idle");
    end
    @(negedge clk);
    bus.sram_ready = 1'b0;
    prev_done = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_idle("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit ird, mrd, mwr;
    int sel;
    bus.if_rd_en = 0; bus.if_addr = '0; bus.mem_rd_en = 0; bus.mem_wr_en = 0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.sram_read_data = '0; bus.sram_ready = 0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_owner", bus.owner, 1'b0);
    chk("rst_ready", {bus.if_ready, bus.mem_ready}, 2'b00);
    chk("rst_en",    {bus.sram_read_en, bus.sram_write_en}, 2'b00);
    chk("rst_addr",  bus.sram_address, 32'h0);
    chk("rst_wdata", bus.sram_write_data, 32'h0);
    chk("rst_rdata", {bus.if_rdata, bus.mem_rdata}, 64'h0);
    chk("rst_terr",  bus.timeout_err, 1'b0);
    rst = 1'b1;

    // MEM read of 0x100
    txn(0, 1, 0, 32'h0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    idle(1);

    // simultaneous IF + MEM write after reset: MEM first, then IF
    pulse_reset();
    txn(1, 0, 1, 32'h200, 32'h300, 32'hCAFE0001, 32'h5555AAAA, 1);
    chk("tie_first_mem", bus.owner, 1'b1);
    txn(1, 0, 0, 32'h200, 32'h300, 32'h0, 32'h600DF00D, 0);
    chk("tie_second_if", bus.owner, 1'b0);

    // both held continuously: strict alternation MEM,IF,...
    for (int i = 0; i < 6; i++) begin
      txn(1, 1, 0, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 2));
      chk("alternate", bus.owner, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    idle(2);

    // address latched: if_addr moves 0x40 -> 0x80 during BUSY
    txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h12345678, 2);
    idle(1);

    // watchdog: no sram_ready, then normal service, then ready on the last cycle
    txn(0, 1, 0, 32'h0, 32'h500, 32'h0, 32'h1111, 10);
    txn(1, 0, 0, 32'h600, 32'h0, 32'h0, 32'h2222, 0);
    txn(0, 1, 1, 32'h0, 32'h700, 32'hABCD, 32'h3333, TO - 1);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      ird = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      mrd = (sel == 1) || (sel == 3);
      mwr = (sel >= 2);
      if (!ird && !mrd && !mwr) ird = 1'b1;
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
      txn(ird, mrd, mwr, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 6));
    end
    idle(1);

    // reset in the middle of BUSY; timeout_err is set from the watchdog test
    bus.if_rd_en = 1'b1; bus.if_addr = 32'h900;
    @(posedge clk); #1;
    chk("mid_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    chk("mid_busy2", bus.busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus.if_rd_en = 1'b0;
    #1;
    model_reset();
    check_idle("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    // sram_ready in IDLE has no effect
    @(negedge clk);
    bus.sram_ready = 1'b1; bus.sram_read_data = 32'hBADBAD00;
    @(posedge clk); #1;
    check_idle("idle_ready");
    chk("idle_rdata", {bus.if_rdata, bus.mem_rdata}, 64'h0);
    @(negedge clk);
    bus.sram_ready = 1'b0;
    txn(1, 0, 0, 32'hA00, 32'h0, 32'h0, 32'h77777777, 1);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller between two requesters: instruction fetch (IF, read-only) and the data-side cache controller (MEM, read/write).
- Sits between both requesters and the SRAM controller.
- Serialises accesses with round-robin arbitration, latches the winner's command, and returns read data and a one-cycle ready pulse to the owner only.
- Includes a watchdog that aborts a hung SRAM transaction.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 255, max cycles in BUSY before abort (8-bit counter; legal range 1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_rd_en  in  1  IF read request (level, held until if_ready)
if_addr  in  ADDR_W  IF address
if_rdata  out  DATA_W  IF read data, valid while if_ready=1
if_ready  out  1  one-cycle completion pulse to IF
mem_rd_en  in  1  MEM read request (level)
mem_wr_en  in  1  MEM write request (level)
mem_addr  in  ADDR_W  MEM address
mem_wdata  in  DATA_W  MEM write data
mem_rdata  out  DATA_W  MEM read data, valid while mem_ready=1
mem_ready  out  1  one-cycle completion pulse to MEM
sram_read_en  out  1  read command to SRAM controller
sram_write_en  out  1  write command to SRAM controller
sram_address  out  ADDR_W  latched address
sram_write_data  out  DATA_W  latched write data
sram_read_data  in  DATA_W  SRAM controller read data
sram_ready  in  1  SRAM controller completion pulse
busy  out  1  high in BUSY or DONE
owner  out  1  current/last grant: 0=IF, 1=MEM
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - All outputs 0.
  - last_grant=IF, so MEM wins the first tie.
  - Latched address/data, counter and timeout_err all cleared.
- Request validity:
  - if_req = if_rd_en.
  - mem_req = mem_rd_en | mem_wr_en.
  - mem_rd_en & mem_wr_en together is treated as a write.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both: grant the requester that is not last_grant.
  - On grant, at the clock edge: latch owner, op (rd/wr), address and wdata; set last_grant=owner; clear counter; go to BUSY.
- BUSY:
  - sram_read_en/sram_write_en driven from registered op, held level until sram_ready.
  - sram_address/sram_write_data come from latches, so requester inputs are ignored while in BUSY.
  - Counter increments each cycle.
  - On sram_ready: capture sram_read_data into the owner's rdata register (writes leave rdata unchanged); enables drop next cycle; go to DONE.
  - If the counter reaches TIMEOUT with no sram_ready: set timeout_err; go to DONE with rdata=0.
  - sram_ready arriving in the same cycle as timeout takes precedence: normal completion, no error.
- DONE (exactly 1 cycle):
  - Owner's ready=1; the other ready stays 0.
  - SRAM enables=0.
  - Always return to IDLE.
  - The owner must deassert or change its request by the cycle after ready; DONE guarantees that a stale request is never re-granted.
- Latency: grant edge to ready = (SRAM cycles until sram_ready) + 1.
  - The minimum, with sram_ready in the first BUSY cycle, is 2 cycles.
- sram_ready while in IDLE or DONE: ignored.
- Request dropped mid-BUSY: the transaction still completes and ready still pulses.
- Reset asserted mid-BUSY:
  - Immediate return to IDLE with enables low.
  - No ready pulse.
  - timeout_err cleared.
- timeout_err is cleared only by reset.
- Fairness: with both requesters continuously active, grants strictly alternate. Worst-case wait is one full transaction.

Test Plan:
- Reset then mem_rd_en=1 with mem_addr=0x100 -> BUSY next cycle with sram_read_en=1 and sram_address=0x100; sram_ready with read_data=0xDEADBEEF -> mem_ready=1 for 1 cycle, mem_rdata=0xDEADBEEF, if_ready=0.
- if_rd_en and mem_wr_en raised in the same cycle after reset -> MEM granted first (write, sram_write_en=1), then IF; owner sequence 1,0.
- Both requesting continuously for 6 transactions -> grants alternate MEM,IF,MEM,IF,MEM,IF; no back-to-back grant to one requester.
- IF request; change if_addr 0x40->0x80 during BUSY -> sram_address stays 0x40 until completion.
- Never assert sram_ready, TIMEOUT=4 -> timeout_err=1 after 4 BUSY cycles, owner ready pulses with rdata=0, state returns to IDLE; next request is served normally.
- Assert rst mid-BUSY -> enables 0 immediately, no ready pulse, timeout_err=0; sram_ready pulse while IDLE -> no effect.
